// File: rtl/multichan_ctrl.sv
// Multi-channel motor control/timing block: per-channel PWM and filter clock
// enables, config/control registers, and a watchdog with warning and trip latch.
module multichan_ctrl #(
  parameter int unsigned NCH     = 3,
  parameter int unsigned BASEDIV = 32,
  parameter int unsigned WDPRE   = 9,
  parameter int unsigned LEDBIT  = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     wrtdata,
  input  logic [NCH-1:0] cfgld,
  input  logic           ctrlld,
  input  logic           wdogdivld,
  input  logic           wdreset,
  input  logic           wdogdis,
  input  logic           tst,
  output logic [NCH-1:0] pwmcntce,
  output logic [NCH-1:0] filterce,
  output logic [NCH-1:0] invertpwm,
  output logic [NCH-1:0] invphase,
  output logic [NCH-1:0] run,
  output logic           motorenaint,
  output logic           wdwarn,
  output logic           ledalive,
  output logic [7:0]     controlrdata,
  output logic [7:0]     hwconfig
);

  localparam int unsigned BW = $clog2(BASEDIV);
  localparam int unsigned LW = WDPRE + LEDBIT + 1;

  logic [BW-1:0]    basecnt;
  logic             basece;
  logic             base_wrap_c;
  logic [4:0]       ctrl;
  logic             wdtrip;
  logic [7:0]       wdogdiv;
  logic [7:0]       wdcnt;
  logic             wdogdis_r;
  logic [WDPRE-1:0] presc;
  logic [WDPRE-1:0] presc_lim_c;
  logic             tst_eff;
  logic [LW-1:0]    ledcnt;
  logic             ctrl_clr_c;
  logic             wdtick_c;
  logic             wden_c;
  logic             trip_c;
  logic [3:0]       runbits_c;

  // Mask of the low d bits of a 7-bit divider counter.
  function automatic logic [6:0] dmask(input logic [2:0] d);
    return 7'((8'd1 << d) - 8'd1);
  endfunction

  assign base_wrap_c = (basecnt == BW'(BASEDIV - 1));
  assign motorenaint = ctrl[4] & ~wdtrip;
  assign ctrl_clr_c  = ctrlld && (wrtdata == 8'h80);
  assign presc_lim_c = tst_eff ? WDPRE'(1) : {WDPRE{1'b1}};
  assign wdtick_c    = basece && (presc == presc_lim_c);
  assign wden_c      = motorenaint & ~wdreset & ~wdogdis_r;
  assign trip_c      = wden_c & wdtick_c & (wdcnt == wdogdiv);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [7:0] cfg_q;
    logic [6:0] pcnt;
    logic [6:0] fcnt;
    logic       pce_q;
    logic       fce_q;
    logic       cfg_wr_c;
    logic [6:0] pmask_c;
    logic [6:0] fmask_c;

    assign cfg_wr_c = cfgld[i] & ~motorenaint;
    assign pmask_c  = dmask(cfg_q[2:0]);
    assign fmask_c  = dmask(cfg_q[5:3]);

    // A config write restarts both dividers so the new ratio is phase-aligned.
    always_ff @(posedge clk) begin
      if (rst) begin
        cfg_q <= '0;
        pcnt  <= '0;
        fcnt  <= '0;
        pce_q <= 1'b0;
        fce_q <= 1'b0;
      end else begin
        if (cfg_wr_c) cfg_q <= wrtdata;
        pcnt <= cfg_wr_c ? 7'd0 : pcnt + 7'd1;
        if (cfg_wr_c)    fcnt <= '0;
        else if (basece) fcnt <= fcnt + 7'd1;
        pce_q <= ((pcnt & pmask_c) == pmask_c);
        fce_q <= base_wrap_c && ((fcnt & fmask_c) == fmask_c);
      end
    end

    assign pwmcntce[i]  = pce_q;
    assign filterce[i]  = fce_q;
    assign invertpwm[i] = cfg_q[6];
    assign invphase[i]  = cfg_q[7];
  end

  // Base tick, watchdog prescaler, control register and watchdog counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      basecnt   <= '0;
      basece    <= 1'b0;
      presc     <= '0;
      tst_eff   <= 1'b0;
      ledcnt    <= '0;
      wdogdis_r <= 1'b0;
      wdogdiv   <= '0;
      ctrl      <= '0;
      wdtrip    <= 1'b0;
      wdcnt     <= '0;
      wdwarn    <= 1'b0;
    end else begin
      basecnt   <= base_wrap_c ? '0 : basecnt + BW'(1);
      basece    <= base_wrap_c;
      wdogdis_r <= wdogdis;
      // Test-mode selection is only sampled at the start of a prescaler period.
      if (presc == '0) tst_eff <= tst;
      if (wdtick_c)    presc <= '0;
      else if (basece) presc <= presc + WDPRE'(1);
      if (basece) ledcnt <= ledcnt + LW'(1);
      if (wdogdivld && !motorenaint) wdogdiv <= wrtdata;
      if (ctrl_clr_c)  ctrl <= '0;
      else if (ctrlld) ctrl <= wrtdata[4:0];
      if (ctrl_clr_c)  wdtrip <= 1'b0;
      else if (trip_c) wdtrip <= 1'b1;
      if (!wden_c || trip_c) wdcnt <= '0;
      else if (wdtick_c)     wdcnt <= wdcnt + 8'd1;
      wdwarn <= wden_c && (wdcnt >= (wdogdiv >> 1)) && (wdogdiv != 8'd0);
    end
  end

  always_comb begin
    runbits_c = '0;
    runbits_c[NCH-1:0] = ctrl[NCH-1:0];
  end

  assign run          = ctrl[NCH-1:0];
  assign ledalive     = ledcnt[LW-1];
  assign controlrdata = {wdtrip, wdogdis_r, wdwarn, ctrl[4], runbits_c};
  assign hwconfig     = {4'b0001, 4'(NCH)};

endmodule

// File: tb/tb_multichan_ctrl.sv
// Directed self-checking bench for multichan_ctrl (NCH=3, BASEDIV=32).
module tb_multichan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wrtdata;
  logic [2:0] cfgld;
  logic       ctrlld;
  logic       wdogdivld;
  logic       wdreset;
  logic       wdogdis;
  logic       tst;
  logic [2:0] pwmcntce;
  logic [2:0] filterce;
  logic [2:0] invertpwm;
  logic [2:0] invphase;
  logic [2:0] run;
  logic       motorenaint;
  logic       wdwarn;
  logic       ledalive;
  logic [7:0] controlrdata;
  logic [7:0] hwconfig;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  multichan_ctrl #(.NCH(3), .BASEDIV(32), .WDPRE(9), .LEDBIT(9)) dut (
    .clk(clk), .rst(rst), .wrtdata(wrtdata), .cfgld(cfgld), .ctrlld(ctrlld),
    .wdogdivld(wdogdivld), .wdreset(wdreset), .wdogdis(wdogdis), .tst(tst),
    .pwmcntce(pwmcntce), .filterce(filterce), .invertpwm(invertpwm),
    .invphase(invphase), .run(run), .motorenaint(motorenaint), .wdwarn(wdwarn),
    .ledalive(ledalive), .controlrdata(controlrdata), .hwconfig(hwconfig)
  );

  always #5 clk = ~clk;

  // Edges since the last reset edge; at the negedge after edge k, cyc == k.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish (cyc=%0d)", cyc);
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic wr_cfg(input logic [2:0] sel, input logic [7:0] d);
    wrtdata = d; cfgld = sel;
    @(negedge clk); cfgld = 3'b000;
  endtask

  task automatic wr_ctrl(input logic [7:0] d);
    wrtdata = d; ctrlld = 1'b1;
    @(negedge clk); ctrlld = 1'b0;
  endtask

  task automatic wr_div(input logic [7:0] d);
    wrtdata = d; wdogdivld = 1'b1;
    @(negedge clk); wdogdivld = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cyc !== n) begin
      errors++;
      $display("FAIL wait_cyc: reached cyc %0d, required %0d", cyc, n);
    end
  endtask

  task automatic test_reset();
    tst = 1'b0;
    do_reset();
    wr_cfg(3'b111, 8'hC3);
    checks++;
    if ({invertpwm, invphase} !== 6'b111111) begin
      errors++; $display("FAIL cfg_multi_load: got %b expected %b", {invertpwm, invphase}, 6'b111111);
    end
    wr_ctrl(8'h1F);
    checks++;
    if (controlrdata !== 8'h17) begin
      errors++; $display("FAIL ctrl_readback: got %h expected %h", controlrdata, 8'h17);
    end
    checks++;
    if ({run, motorenaint} !== 4'b1111) begin
      errors++; $display("FAIL ctrl_run_ena: got %b expected %b", {run, motorenaint}, 4'b1111);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({pwmcntce, filterce, run} !== 9'b0) begin
      errors++; $display("FAIL reset_ce_run: got %b expected %b", {pwmcntce, filterce, run}, 9'b0);
    end
    checks++;
    if ({motorenaint, wdwarn, ledalive} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected %b", {motorenaint, wdwarn, ledalive}, 3'b000);
    end
    checks++;
    if (controlrdata !== 8'h00) begin
      errors++; $display("FAIL reset_controlrdata: got %h expected %h", controlrdata, 8'h00);
    end
    checks++;
    if (hwconfig !== 8'h13) begin
      errors++; $display("FAIL hwconfig: got %h expected %h", hwconfig, 8'h13);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({invertpwm, invphase} !== 6'b0) begin
      errors++; $display("FAIL reset_cfg: got %b expected %b", {invertpwm, invphase}, 6'b0);
    end
    checks++;
    if (pwmcntce !== 3'b111) begin
      errors++; $display("FAIL reset_pwm_pd0: got %b expected %b", pwmcntce, 3'b111);
    end
  endtask

  task automatic test_pwm_divide();
    logic exp1;
    wr_cfg(3'b010, 8'h02);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp1 = ((k % 4) == 0);
      checks++;
      if ({pwmcntce[2], exp1, pwmcntce[0]} !== {1'b1, pwmcntce[1], 1'b1}) begin
        errors++; $display("FAIL pwm_div4 k=%0d: got %b expected %b", k, pwmcntce, {1'b1, exp1, 1'b1});
      end
    end
    wr_ctrl(8'h10);
    checks++;
    if (motorenaint !== 1'b1) begin
      errors++; $display("FAIL pwm_ena: got %b expected %b", motorenaint, 1'b1);
    end
    wr_cfg(3'b001, 8'h05);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (pwmcntce[0] !== 1'b1) begin
        errors++; $display("FAIL cfg_drop k=%0d: got %b expected %b", k, pwmcntce[0], 1'b1);
      end
    end
    wr_ctrl(8'h00);
  endtask

  task automatic test_filter_divide();
    do_reset();
    wr_cfg(3'b100, 8'h18);
    wait_cyc(32);
    checks++;
    if (filterce !== 3'b011) begin
      errors++; $display("FAIL filt_fd0_pulse: got %b expected %b", filterce, 3'b011);
    end
    wait_cyc(33);
    checks++;
    if (filterce !== 3'b000) begin
      errors++; $display("FAIL filt_fd0_width: got %b expected %b", filterce, 3'b000);
    end
    wait_cyc(255);
    checks++;
    if (filterce[2] !== 1'b0) begin
      errors++; $display("FAIL filt_fd3_early: got %b expected %b", filterce[2], 1'b0);
    end
    wait_cyc(256);
    checks++;
    if (filterce[2] !== 1'b1) begin
      errors++; $display("FAIL filt_fd3_first: got %b expected %b", filterce[2], 1'b1);
    end
    wait_cyc(257);
    checks++;
    if (filterce[2] !== 1'b0) begin
      errors++; $display("FAIL filt_fd3_width: got %b expected %b", filterce[2], 1'b0);
    end
    wait_cyc(480);
    checks++;
    if (filterce[2] !== 1'b0) begin
      errors++; $display("FAIL filt_fd3_mid: got %b expected %b", filterce[2], 1'b0);
    end
    wait_cyc(512);
    checks++;
    if (filterce[2] !== 1'b1) begin
      errors++; $display("FAIL filt_fd3_second: got %b expected %b", filterce[2], 1'b1);
    end
  endtask

  task automatic test_watchdog_trip();
    tst = 1'b1;
    do_reset();
    wr_div(8'd4);
    wr_ctrl(8'h17);
    wait_cyc(129);
    checks++;
    if (wdwarn !== 1'b0) begin
      errors++; $display("FAIL wdwarn_early: got %b expected %b", wdwarn, 1'b0);
    end
    wait_cyc(130);
    checks++;
    if (wdwarn !== 1'b1) begin
      errors++; $display("FAIL wdwarn_rise: got %b expected %b", wdwarn, 1'b1);
    end
    wait_cyc(320);
    checks++;
    if ({controlrdata[7], motorenaint} !== 2'b01) begin
      errors++; $display("FAIL trip_early: got %b expected %b", {controlrdata[7], motorenaint}, 2'b01);
    end
    wait_cyc(321);
    checks++;
    if (controlrdata !== 8'hB7) begin
      errors++; $display("FAIL trip_readback: got %h expected %h", controlrdata, 8'hB7);
    end
    checks++;
    if ({motorenaint, run} !== 4'b0111) begin
      errors++; $display("FAIL trip_ena_run: got %b expected %b", {motorenaint, run}, 4'b0111);
    end
    wait_cyc(322);
    checks++;
    if (controlrdata !== 8'h97) begin
      errors++; $display("FAIL trip_warn_drop: got %h expected %h", controlrdata, 8'h97);
    end
  endtask

  task automatic test_kick_disable();
    tst = 1'b1;
    do_reset();
    wr_div(8'd4);
    wr_ctrl(8'h10);
    for (int k = 0; k < 5; k++) begin
      wait_cyc(192 * k + 100);
      wdreset = 1'b1;
      @(negedge clk);
      wdreset = 1'b0;
    end
    wait_cyc(1050);
    checks++;
    if ({controlrdata[7], motorenaint, wdwarn} !== 3'b011) begin
      errors++; $display("FAIL kick_no_trip: got %b expected %b", {controlrdata[7], motorenaint, wdwarn}, 3'b011);
    end
    wdogdis = 1'b1;
    wait_cyc(1500);
    checks++;
    if (controlrdata !== 8'h50) begin
      errors++; $display("FAIL wdogdis_hold: got %h expected %h", controlrdata, 8'h50);
    end
    checks++;
    if (motorenaint !== 1'b1) begin
      errors++; $display("FAIL wdogdis_ena: got %b expected %b", motorenaint, 1'b1);
    end
    wdogdis = 1'b0;
  endtask

  task automatic test_clear_race();
    tst = 1'b1;
    do_reset();
    wr_div(8'd0);
    wr_ctrl(8'h10);
    wait_cyc(64);
    checks++;
    if ({controlrdata[7], motorenaint} !== 2'b01) begin
      errors++; $display("FAIL race_pre: got %b expected %b", {controlrdata[7], motorenaint}, 2'b01);
    end
    wrtdata = 8'h80; ctrlld = 1'b1;
    @(negedge clk); ctrlld = 1'b0;
    checks++;
    if ({controlrdata, motorenaint} !== 9'h000) begin
      errors++; $display("FAIL race_clear_wins: got %h expected %h", {controlrdata, motorenaint}, 9'h000);
    end
    wr_ctrl(8'h10);
    checks++;
    if ({controlrdata, motorenaint} !== {8'h10, 1'b1}) begin
      errors++; $display("FAIL race_reenable: got %h expected %h", {controlrdata, motorenaint}, {8'h10, 1'b1});
    end
    wait_cyc(129);
    checks++;
    if ({controlrdata[7], motorenaint} !== 2'b10) begin
      errors++; $display("FAIL div0_first_tick: got %b expected %b", {controlrdata[7], motorenaint}, 2'b10);
    end
    wr_ctrl(8'h80);
    checks++;
    if (controlrdata !== 8'h00) begin
      errors++; $display("FAIL trip_clear: got %h expected %h", controlrdata, 8'h00);
    end
  endtask

  initial begin
    rst = 1'b1; wrtdata = '0; cfgld = '0; ctrlld = 1'b0; wdogdivld = 1'b0;
    wdreset = 1'b0; wdogdis = 1'b0; tst = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_pwm_divide();
    test_filter_divide();
    test_watchdog_trip();
    test_kick_disable();
    test_clear_race();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multichan_ctrl.md
Name: multichan_ctrl

Overview:
- Parametrised successor to the three-channel motor control/timing block.
- Generates per-channel PWM-count and filter clock enables from programmable power-of-2 dividers.
- Holds per-channel config registers, the control/run register and a watchdog with half-timeout warning and trip latch.
- Sits between the host register decoder and the NCH PWM/filter channels.

Parameters:
- NCH, 3, channel count, 1..4.
- BASEDIV, 32, system clocks per base tick; power of 2, at least 2.
- WDPRE, 9, watchdog tick = base tick / 2^WDPRE in normal mode; tst mode uses base tick / 2.
- LEDBIT, 9, bit of the watchdog-tick counter driven to ledalive.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- wrtdata  in  8  host write data.
- cfgld  in  NCH  per-channel config register load strobe.
- ctrlld  in  1  control register load strobe.
- wdogdivld  in  1  watchdog timeout register load strobe.
- wdreset  in  1  watchdog kick, level; holds the counter at 0 while high.
- wdogdis  in  1  watchdog disable.
- tst  in  1  test mode; fast watchdog tick.
- pwmcntce  out  NCH  per-channel PWM counter enable.
- filterce  out  NCH  per-channel filter enable.
- invertpwm  out  NCH  config bit 6.
- invphase  out  NCH  config bit 7.
- run  out  NCH  control bits [NCH-1:0].
- motorenaint  out  1  ctrl[4] & ~wdtrip.
- wdwarn  out  1  watchdog past half timeout.
- ledalive  out  1  alive blink.
- controlrdata  out  8  {wdtrip, wdogdis, wdwarn, ctrl[4], ctrl[3:0]}, with run bits above NCH reading 0.
- hwconfig  out  8  {4'b0001, NCH[3:0]}.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- On rst, every register clears to 0: config, ctrl, wdogdiv, all counters, wdtrip, and the registered enables. With rst high, all ce outputs, run, motorenaint, wdwarn and ledalive are 0.

Base tick:
- Free-running counter modulo BASEDIV.
- basece is a registered 1-clock pulse, first asserted BASEDIV clocks after rst falls.

Config register, per channel:
- Bits: [2:0] pd (pwm divider), [5:3] fd (filter divider), [6] invertpwm, [7] invphase.
- Written on cfgld[i] only when motorenaint=0; writes while enabled are silently dropped.
- A simultaneous multi-bit cfgld loads every selected channel.

pwmcntce[i]:
- A 7-bit per-channel counter increments every clk.
- pwmcntce[i] = 1 when counter low pd bits are all 1, i.e. divide by 2^pd (pd=0: continuously 1).
- A config write clears that channel's counter the same edge, so the new ratio is phase-aligned.

filterce[i]:
- Same scheme clocked by basece, fd select.
- Output is gated with basece, giving a 1-clock pulse every BASEDIV*2^fd clocks.

Control register:
- ctrlld loads ctrl[4:0] from wrtdata[4:0]; wrtdata bits 7:5 are ignored.
- Writing exactly 8'h80 clears wdtrip, and also loads ctrl=0.
- If the trip pulse and the 8'h80 write occur on the same edge, the clear wins.

Watchdog:
- wdtick = basece divided by 2^WDPRE (tst=0) or by 2 (tst=1).
- The tst change takes effect at the next prescaler wrap.
- wdogdiv is loaded on wdogdivld only when motorenaint=0.
- wdogdis is registered once before use.
- The 8-bit counter clears when any of these holds: motorenaint=0, wdreset=1, or wdogdis_r=1. Otherwise it increments on wdtick.
- On wdtick with counter==wdogdiv, wdtrip sets the next edge, motorenaint drops the same edge, and the counter clears.
- The counter never wraps past wdogdiv.
- wdogdiv=0 trips on the first wdtick after enable.
- wdwarn = enable-qualified (counter >= (wdogdiv>>1)) && wdogdiv!=0. It is registered, so it lags by 1 clk.
- wdtrip persists until the 8'h80 write or rst; while set, motorenaint=0 regardless of ctrl[4].

ledalive:
- Bit LEDBIT of a free-running counter of wdtick at normal rate.

Test Plan:
- Reset: drive writes, then assert rst 1 clk → all outputs 0, controlrdata=8'h00, hwconfig=8'h13 (NCH=3); a cfg read-back path after release is 0.
- PWM divide: cfgld[1] with 8'h02 → pwmcntce[1] pulses every 4 clk starting 4 clk after load; channels 0/2 stay continuously 1; write 8'h05 to ch0 while ctrl=8'h10 → dropped, ch0 unchanged.
- Filter divide, BASEDIV=32: fd=3 (8'h18) → filterce 1-clk pulse every 256 clk.
- Watchdog trip, tst=1, wdogdiv=4, ctrl=8'h17: no kick → wdwarn rises at count 2, trip after 5 wdticks (~320 clk); motorenaint=0; controlrdata[7]=1; run bits still read 1.
- Kick/disable: pulse wdreset every 3 wdticks → never trips; wdogdis=1 → counter held 0, controlrdata[6]=1.
- Clear race: trip pulse coincident with an 8'h80 write → wdtrip=0, ctrl=0; afterwards write 8'h10 → motorenaint=1.
